// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data RAM between the processor's MEM stage (port C)
// and the external parallel read-out path (port R). Port C has priority.
// A saturating wait counter makes sure port R wins a contested cycle after
// MAX_WAIT consecutive denials. Each granted read is tagged, so its data is
// returned to the requester that issued it one cycle later.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata   port C request (held until c_gnt)
//   c_gnt, c_stall      port C grant, stall toward the hazard logic
//   c_rvalid, c_rdata   port C read return
//   r_req/r_addr        port R read request (held until r_gnt)
//   r_gnt               port R grant
//   r_rvalid, r_rdata   port R read return
//   mem_en/mem_we/mem_addr/mem_wdata   RAM access port
//   mem_rdata           RAM read data, valid one cycle after the access
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW       = 24,
    parameter int DW       = 24,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,

    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_gnt,
    output logic          r_rvalid,
    output logic [DW-1:0] r_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       tag_c;
    logic       tag_r;
    logic       r_wins;

    // Port R only takes a contested cycle once it has been denied MAX_WAIT
    // cycles in a row; the counter saturates there, so equality is enough.
    assign r_wins = (wait_cnt == WAIT_LIMIT);

    always_comb begin
        c_gnt = 1'b0;
        r_gnt = 1'b0;
        if (!rst) begin
            if (c_req && r_req) begin
                c_gnt = !r_wins;
                r_gnt = r_wins;
            end else begin
                c_gnt = c_req;
                r_gnt = r_req;
            end
        end
    end

    assign c_stall = c_req & ~c_gnt;

    // Port R is read-only, so it never contributes write data or a write enable.
    always_comb begin
        mem_en    = c_gnt | r_gnt;
        mem_we    = c_gnt & c_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (r_gnt) begin
            mem_addr  = r_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            tag_c    <= 1'b0;
            tag_r    <= 1'b0;
        end else begin
            if (r_req && !r_gnt) begin
                if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end else begin
                wait_cnt <= '0;
            end
            tag_c <= c_gnt & ~c_we;
            tag_r <= r_gnt;
        end
    end

    // The tags were set by the cycle before reset; masking with rst drops a
    // read that was in flight when reset arrived.
    assign c_rvalid = tag_c & ~rst;
    assign r_rvalid = tag_r & ~rst;
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign r_rdata  = r_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 24;
    localparam int DW = 24;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          rst;
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt, c_stall, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          r_req;
    logic [AW-1:0] r_addr;
    logic          r_gnt, r_rvalid;
    logic [DW-1:0] r_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks;
    int failures;

    logic [DW-1:0] ram    [logic [AW-1:0]];
    logic [DW-1:0] shadow [logic [AW-1:0]];

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_stall  (c_stall),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .r_req    (r_req),
        .r_addr   (r_addr),
        .r_gnt    (r_gnt),
        .r_rvalid (r_rvalid),
        .r_rdata  (r_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : '0;
        end
    end

    task automatic drive(input logic rs, input logic cr, input logic cw,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic rr, input logic [AW-1:0] ra);
        @(posedge clk);
        #1;
        rst = rs; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        r_req = rr; r_addr = ra;
    endtask

    // {c_gnt, r_gnt, c_stall, mem_en, mem_we}
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 24'h000123, 24'h000456, 1, 24'h000789);
            @(negedge clk);
            checks++;
            if ({c_gnt, r_gnt, c_stall, mem_en, mem_we} !== 5'b00100) begin
                failures++;
                $display("FAIL reset_ctrl cyc=%0d got=%b exp=00100", i,
                         {c_gnt, r_gnt, c_stall, mem_en, mem_we});
            end
            checks++;
            if ({c_rvalid, r_rvalid, c_rdata, r_rdata, mem_addr, mem_wdata} !== '0) begin
                failures++;
                $display("FAIL reset_data cyc=%0d c_rv=%b r_rv=%b mem_addr=%h mem_wdata=%h exp all 0",
                         i, c_rvalid, r_rvalid, mem_addr, mem_wdata);
            end
        end
        drive(0, 0, 0, '0, '0, 0, '0);
        @(negedge clk);
        checks++;
        if ({c_rvalid, r_rvalid, c_rdata, r_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_after_rvalid got c_rv=%b r_rv=%b exp 0 0", c_rvalid, r_rvalid);
        end
    endtask

    task automatic test_c_write_read();
        drive(0, 1, 1, 24'h000010, 24'h00ABCD, 0, '0);
        @(negedge clk);
        checks++;
        if ({c_gnt, r_gnt, c_stall, mem_en, mem_we, mem_addr, mem_wdata} !==
            {5'b10011, 24'h000010, 24'h00ABCD}) begin
            failures++;
            $display("FAIL c_write got ctrl=%b addr=%h wdata=%h exp 10011 000010 00abcd",
                     {c_gnt, r_gnt, c_stall, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        drive(0, 1, 0, 24'h000010, 24'h000000, 0, '0);
        @(negedge clk);
        checks++;
        if ({c_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 24'h000010}) begin
            failures++;
            $display("FAIL c_read got gnt/en/we=%b addr=%h exp 110 000010",
                     {c_gnt, mem_en, mem_we}, mem_addr);
        end
        checks++;
        if (c_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL c_write_no_rvalid got=%b exp=0", c_rvalid);
        end
        drive(0, 0, 0, '0, '0, 0, '0);
        @(negedge clk);
        checks++;
        if ({c_rvalid, c_rdata, r_rvalid, mem_en} !== {1'b1, 24'h00ABCD, 2'b00}) begin
            failures++;
            $display("FAIL c_read_return got c_rv=%b c_rdata=%h r_rv=%b en=%b exp 1 00abcd 0 0",
                     c_rvalid, c_rdata, r_rvalid, mem_en);
        end
    endtask

    task automatic test_r_alone();
        for (int i = 1; i <= 4; i++) begin
            if (i <= 3) drive(0, 0, 0, '0, '0, 1, 24'h000010);
            else drive(0, 0, 0, '0, '0, 0, '0);
            @(negedge clk);
            checks++;
            if ({r_gnt, mem_en, mem_we, c_stall} !== {(i <= 3), (i <= 3), 2'b00} ||
                (i <= 3 && mem_addr !== 24'h000010)) begin
                failures++;
                $display("FAIL r_alone_grant cyc=%0d got gnt/en/we/stall=%b addr=%h",
                         i, {r_gnt, mem_en, mem_we, c_stall}, mem_addr);
            end
            checks++;
            if ({r_rvalid, r_rdata, c_rvalid} !== ((i >= 2) ? {1'b1, 24'h00ABCD, 1'b0} : 26'd0)) begin
                failures++;
                $display("FAIL r_alone_return cyc=%0d got r_rv=%b r_rdata=%h c_rv=%b",
                         i, r_rvalid, r_rdata, c_rvalid);
            end
        end
    endtask

    task automatic test_starvation();
        drive(0, 0, 0, '0, '0, 0, '0);
        for (int i = 1; i <= 12; i++) begin
            logic exp_r;
            exp_r = ((i % (MAX_WAIT + 1)) == 0);
            drive(0, 1, 0, 24'h000010, '0, 1, 24'h000020);
            @(negedge clk);
            checks++;
            if ({r_gnt, c_gnt, c_stall, mem_en} !== {exp_r, !exp_r, exp_r, 1'b1}) begin
                failures++;
                $display("FAIL starvation cyc=%0d got r_gnt=%b c_gnt=%b stall=%b exp r_gnt=%b",
                         i, r_gnt, c_gnt, c_stall, exp_r);
            end
        end
        drive(0, 0, 0, '0, '0, 0, '0);
    endtask

    task automatic test_write_vs_pending_r();
        for (int i = 1; i <= 4; i++) drive(0, 1, 0, 24'h000030, '0, 1, 24'h000010);
        drive(0, 1, 1, 24'h000040, 24'h123456, 1, 24'h000010);
        @(negedge clk);
        checks++;
        if ({r_gnt, c_gnt, c_stall, mem_we, mem_addr, mem_wdata} !==
            {4'b1010, 24'h000010, 24'h000000}) begin
            failures++;
            $display("FAIL wr_vs_r_grant got r/c/stall/we=%b addr=%h wdata=%h exp 1010 000010 000000",
                     {r_gnt, c_gnt, c_stall, mem_we}, mem_addr, mem_wdata);
        end
        checks++;
        if ({c_rvalid, c_rdata} !== {1'b1, 24'h000000}) begin
            failures++;
            $display("FAIL wr_vs_r_prev_read got c_rv=%b c_rdata=%h exp 1 000000", c_rvalid, c_rdata);
        end
        drive(0, 1, 1, 24'h000040, 24'h123456, 0, '0);
        @(negedge clk);
        checks++;
        if ({c_gnt, c_stall, mem_we, mem_addr, mem_wdata} !== {3'b101, 24'h000040, 24'h123456}) begin
            failures++;
            $display("FAIL wr_vs_r_write got gnt/stall/we=%b addr=%h wdata=%h exp 101 000040 123456",
                     {c_gnt, c_stall, mem_we}, mem_addr, mem_wdata);
        end
        checks++;
        if ({r_rvalid, r_rdata, c_rvalid} !== {1'b1, 24'h00ABCD, 1'b0}) begin
            failures++;
            $display("FAIL wr_vs_r_return got r_rv=%b r_rdata=%h c_rv=%b exp 1 00abcd 0",
                     r_rvalid, r_rdata, c_rvalid);
        end
        drive(0, 1, 0, 24'h000040, '0, 0, '0);
        drive(0, 0, 0, '0, '0, 0, '0);
        @(negedge clk);
        checks++;
        if ({c_rvalid, c_rdata} !== {1'b1, 24'h123456}) begin
            failures++;
            $display("FAIL wr_vs_r_readback got c_rv=%b c_rdata=%h exp 1 123456", c_rvalid, c_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        drive(0, 1, 0, 24'h000040, '0, 0, '0);
        @(negedge clk);
        checks++;
        if (c_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_read_grant got=%b exp=1", c_gnt);
        end
        for (int i = 1; i <= 2; i++) begin
            drive((i == 1), 0, 0, '0, '0, 0, '0);
            @(negedge clk);
            checks++;
            if ({c_rvalid, c_rdata, r_rvalid} !== '0) begin
                failures++;
                $display("FAIL mid_read_discard cyc=n+%0d got c_rv=%b c_rdata=%h exp 0 000000",
                         i, c_rvalid, c_rdata);
            end
        end
    endtask

    // Requesters hold their requests until granted; the model follows the
    // arbitration rules directly and keeps its own copy of memory contents.
    task automatic test_random();
        int streak = 0;
        bit cp = 0, rp = 0, cwe = 0;
        logic [AW-1:0] ca = '0, ra = '0;
        logic [DW-1:0] cd = '0;
        bit ecv = 0, erv = 0;
        logic [DW-1:0] ecd = '0, erd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit rs, cg, rg, ecv_now, erv_now;
            logic [AW-1:0] ea;
            logic [DW-1:0] ed;
            rs = (cyc == 0) || ($urandom_range(0, 39) == 0);
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp = 1; cwe = 1'($urandom_range(0, 1));
                ca = {4'($urandom_range(0, 15)), 16'h5A5A, 4'($urandom_range(0, 15))};
                cd = 24'($urandom);
            end
            if (!rp && $urandom_range(0, 1) != 0) begin
                rp = 1;
                ra = {4'($urandom_range(0, 15)), 16'h5A5A, 4'($urandom_range(0, 15))};
            end
            drive(rs, cp, cwe, ca, cd, rp, ra);

            cg = !rs && cp && !(rp && streak >= MAX_WAIT);
            rg = !rs && rp && !cg;
            ea = cg ? ca : (rg ? ra : '0);
            ed = cg ? cd : '0;
            ecv_now = ecv && !rs;
            erv_now = erv && !rs;

            @(negedge clk);
            checks++;
            if ({c_gnt, r_gnt, c_stall, mem_en, mem_we, mem_addr, mem_wdata} !==
                {cg, rg, cp && !cg, cg || rg, cg && cwe, ea, ed}) begin
                failures++;
                $display("FAIL rand_port cyc=%0d got c/r/stall/en/we=%b addr=%h wd=%h exp %b %h %h",
                         cyc, {c_gnt, r_gnt, c_stall, mem_en, mem_we}, mem_addr, mem_wdata,
                         {cg, rg, cp && !cg, cg || rg, cg && cwe}, ea, ed);
            end
            checks++;
            if ({c_rvalid, c_rdata, r_rvalid, r_rdata} !==
                {ecv_now, ecv_now ? ecd : 24'h0, erv_now, erv_now ? erd : 24'h0}) begin
                failures++;
                $display("FAIL rand_return cyc=%0d got c=%b/%h r=%b/%h exp c=%b/%h r=%b/%h",
                         cyc, c_rvalid, c_rdata, r_rvalid, r_rdata,
                         ecv_now, ecv_now ? ecd : 24'h0, erv_now, erv_now ? erd : 24'h0);
            end

            if (rs) begin
                streak = 0; ecv = 0; erv = 0;
            end else begin
                streak = (rp && !rg) ? ((streak < MAX_WAIT) ? streak + 1 : MAX_WAIT) : 0;
                ecv = cg && !cwe;
                ecd = shadow.exists(ca) ? shadow[ca] : '0;
                erv = rg;
                erd = shadow.exists(ra) ? shadow[ra] : '0;
                if (cg && cwe) shadow[ca] = cd;
                if (cg) cp = 0;
                if (rg) rp = 0;
            end
        end
        drive(0, 0, 0, '0, '0, 0, '0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; r_req = 0; r_addr = '0;
        test_reset();
        test_c_write_read();
        test_r_alone();
        test_starvation();
        test_write_vs_pending_r();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data RAM between two requesters: the processor's MEM stage (port C) and the external parallel read-out path (port R, driven by parallelAddress, returning q). Port C has priority. A wait counter guarantees port R a slot after a bounded number of denied cycles. The block drives the RAM port and tags each read so its data returns to the correct requester one cycle later. It also raises a stall toward the hazard logic whenever port C is denied.

## Interface

Parameters:
- AW, 24: address width.
- DW, 24: data word width (matches RW).
- MAX_WAIT, 4: consecutive denied cycles after which port R wins a contested cycle. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  port C access request; held with its address/data until c_gnt.
- c_we  in  1  port C write (1) or read (0).
- c_addr  in  AW  port C address.
- c_wdata  in  DW  port C write data.
- c_gnt  out  1  port C owns the RAM this cycle.
- c_stall  out  1  c_req & !c_gnt; feeds the pipeline stall.
- c_rvalid  out  1  port C read data valid.
- c_rdata  out  DW  port C read data.
- r_req  in  1  port R read request; port R is read-only.
- r_addr  in  AW  port R address.
- r_gnt  out  1  port R owns the RAM this cycle.
- r_rvalid  out  1  port R read data valid.
- r_rdata  out  DW  port R read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after the access.

## Operation

Arbitration (combinational from requests and registered wait_cnt):
- Neither port requests: no grant; mem_en=0.
- Only one port requests: that port is granted.
- Both ports request and wait_cnt < MAX_WAIT: port C is granted.
- Both ports request and wait_cnt == MAX_WAIT: port R is granted.

RAM mux:
- mem_en = c_gnt | r_gnt.
- mem_we = c_gnt & c_we. It is never 1 on a port R grant.
- mem_addr and mem_wdata come from the granted port.
- With no grant, mem_addr and mem_wdata are 0.

wait_cnt (registered, 4 bits):
- Increments when r_req & !r_gnt, saturating at MAX_WAIT.
- Clears to 0 when r_gnt is 1 or r_req is 0.

Read tag (registered):
- tag_c <= c_gnt & !c_we.
- tag_r <= r_gnt.

Return path:
- c_rvalid = tag_c; r_rvalid = tag_r.
- c_rdata = mem_rdata when tag_c is 1, otherwise 0.
- r_rdata = mem_rdata when tag_r is 1, otherwise 0.
- Writes produce no rvalid.

Reset:
- While rst=1: c_gnt, r_gnt and mem_en are forced to 0; c_stall = c_req.
- On the edge with rst=1: wait_cnt, tag_c and tag_r clear to 0.
- An in-flight read issued the cycle before rst is discarded; no rvalid follows reset.

## Timing

- Grant is issued in the same cycle as the request when the port wins. The RAM samples on that edge.
- Read latency: rvalid is asserted exactly 1 cycle after the granted cycle.
- Write latency: the RAM is updated at the granting edge.
- Back-to-back accesses: a grant is possible every cycle. Port C reads on cycles n and n+1 give c_rvalid on n+1 and n+2.
- Reset values: c_gnt=0, r_gnt=0, c_rvalid=0, r_rvalid=0, c_rdata=0, r_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, c_stall=c_req.
- Contention bound: under continuous contention, port R is granted at most every MAX_WAIT+1 cycles. Port C stalls exactly 1 cycle per port R win.
- A requester must hold its request stable until granted. Dropping r_req clears wait_cnt.

## Test plan

- Reset: assert rst for 2 cycles with c_req=1 and r_req=1 -> no grant, mem_en=0, c_stall=1, and no rvalid in the cycle after rst falls.
- Port C write then read: write 0x00ABCD to address 0x000010, then read address 0x000010 -> c_gnt on both cycles; c_rvalid=1 with c_rdata=0x00ABCD one cycle after the read; r_rvalid stays 0.
- Port R alone: r_addr=0x000010 held for 3 cycles -> r_gnt=1 each cycle, mem_we=0, and r_rvalid=1 on cycles 2..4 with r_rdata=0x00ABCD.
- Starvation guard (MAX_WAIT=4): c_req=1 and r_req=1 continuously for 12 cycles -> r_gnt on cycles 5 and 10 only; c_stall=1 on exactly those cycles; wait_cnt returns to 0 after each port R grant.
- Port C write against a pending port R read: wait_cnt=4, c_we=1 -> port R is granted and c_stall=1. Port C's write lands on the next cycle, and mem_we is never 1 during the port R grant.
- Reset mid-read: grant a port C read at cycle n and assert rst at cycle n+1 -> c_rvalid stays 0 at n+1 and n+2.
